vga_crtc: RTL and testbench
===========================

// Module: vga_crtc
// PURPOSE
//   Video timing generator for the v65C02 80x30 text display; stage directly upstream of Synchronizer.
//   Divides the system clock into a pixel enable and runs horizontal/vertical counters (640x480@60).
//   Emits raw hsync/vsync/video_on, character row/column, glyph pixel coordinates and cursor flag.
//   All outputs are co-timed; the video RAM/char ROM/Synchronizer pipeline applies its own alignment delay.
// PARAMETERS
//   CLK_DIV       4    system clocks per pixel (100 MHz -> 25 MHz)
//   H_DISPLAY   640    visible pixels per line
//   H_FRONT      16    h front porch;  H_SYNC 96 h sync width;  H_BACK 48 h back porch
//   V_DISPLAY   480    visible lines per frame
//   V_FRONT      10    v front porch;  V_SYNC  2 v sync width;  V_BACK 33 v back porch
//   CURSOR_TOP   14    first glyph line (0-15) of underline cursor
//   BLINK_FRAMES 16    frames per cursor blink half-period
// PORTS
//   clk_i         in   1   system clock, 100 MHz
//   rst_ni        in   1   asynchronous active-low reset
//   cursor_en_i   in   1   cursor display enable
//   cursor_col_i  in   7   cursor character column 0-79
//   cursor_row_i  in   5   cursor character row 0-29
//   en_o          out  1   pixel enable, one-clock pulse every CLK_DIV clocks (drives Synchronizer en_i)
//   hsync_o       out  1   horizontal sync, active low
//   vsync_o       out  1   vertical sync, active low
//   video_on_o    out  1   high inside the 640x480 visible area
//   col_o         out  7   character column = h_count[9:3]
//   row_o         out  5   character row    = v_count[8:4]
//   glyph_x_o     out  3   pixel within glyph = h_count[2:0]
//   glyph_y_o     out  4   line within glyph  = v_count[3:0]
//   cursor_o      out  1   current pixel belongs to visible cursor
//   frame_o       out  1   one-clock pulse at start of vsync (VBL interrupt to CPU)
// BEHAVIOUR
//   - Reset (async assert, sync release): div, h_count, v_count, blink counter = 0; en_o = 0;
//     hsync_o = vsync_o = 1; video_on_o = 0; cursor_o = 0; frame_o = 0; blink phase = 1 (visible);
//     latched cursor position = 0.
//   - Divider: counts 0..CLK_DIV-1, wraps; en_o asserts the clock that div == CLK_DIV-1.
//   - h_count (10 b) advances only on en_o; 0..H_TOTAL-1 (H_TOTAL = 800), wraps to 0.
//   - v_count (10 b) advances on en_o when h_count == H_TOTAL-1; 0..V_TOTAL-1 (525), wraps to 0.
//   - All video outputs registered; they update on the same edge as the counters. Values therefore
//     describe the pixel whose counters are current; en_o is high with valid, stable data.
//   - hsync_o = 0 for h in [656,751]; vsync_o = 0 for v in [490,491]; video_on_o = h<640 && v<480.
//   - col/row/glyph outputs driven from counters at all times; meaningful only while video_on_o.
//   - frame_o pulses for one clk on the en_o that moves v_count to V_DISPLAY+V_FRONT (h wraps to 0).
//   - Cursor position/enable latched on that same en_o (during blanking), so no mid-frame tear.
//   - Blink: counter increments at each frame_o; at BLINK_FRAMES-1 it wraps and blink phase toggles.
//   - cursor_o = video_on && cursor_en_l && blink && col==col_l && row==row_l && glyph_y>=CURSOR_TOP.
//   - Out-of-range cursor_col_i (>79) or cursor_row_i (>29): latched as-is, never matches, no cursor.
//   - Simultaneous h and v wrap (800x525 end): both counters go to 0 on one en_o; no extra line.
//   - Reset mid-frame: all state returns to reset values at once; next frame starts at h=v=0.
// TESTING
//   - Reset release -> en_o first high on clk 4, then every 4 clks; hsync_o=vsync_o=1, video_on_o=1 at h=v=0.
//   - Line timing -> hsync_o falls when h=656, rises at h=752 (96 px); video_on_o low at h=640..799.
//   - Frame timing -> vsync_o low for v=490..491 (1600 px); frame_o exactly once per 1,680,000 clks.
//   - Counter mapping: h=17, v=35 -> col_o=2, row_o=2, glyph_x_o=1, glyph_y_o=3.
//   - Cursor en=1 col=5 row=3 -> cursor_o high only h=40..47, v=62..63 while blink=1;
//     absent for the next 16 frames after the 16th frame_o; col=80 -> never high.
//   - Cursor position changed mid-frame -> cursor_o unchanged until after next frame_o.
//   - rst_ni pulsed low at h=300,v=200 -> outputs return to reset values at once; restart from h=v=0.

Source files
------------

// File: rtl/vga_crtc.sv
// 640x480@60 video timing generator for the 80x30 text display.
// Produces pixel enable, syncs, character/glyph coordinates and blinking cursor flag.
module vga_crtc #(
    parameter int CLK_DIV      = 4,
    parameter int H_DISPLAY    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_DISPLAY    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int CURSOR_TOP   = 14,
    parameter int BLINK_FRAMES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cursor_en_i,
    input  logic [6:0] cursor_col_i,
    input  logic [4:0] cursor_row_i,
    output logic       en_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       video_on_o,
    output logic [6:0] col_o,
    output logic [4:0] row_o,
    output logic [2:0] glyph_x_o,
    output logic [3:0] glyph_y_o,
    output logic       cursor_o,
    output logic       frame_o
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP   = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP   = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] VS_PRE   = 10'(V_DISPLAY + V_FRONT - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [3:0] CUR_TOP  = 4'(CURSOR_TOP);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             blink_q, blink_d;
    logic             cen_q, cen_d;
    logic [6:0]       ccol_q, ccol_d;
    logic [4:0]       crow_q, crow_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             von_q, von_d;
    logic             cursor_q, cursor_d;
    logic             frame_q, frame_d;
    logic             en;
    logic             h_last;

    always_comb begin
        en      = (div_q == DIV_LAST);
        h_last  = (h_q == H_LAST);
        div_d   = en ? '0 : div_q + DIV_W'(1);
        h_d     = h_q;
        v_d     = v_q;
        bcnt_d  = bcnt_q;
        blink_d = blink_q;
        cen_d   = cen_q;
        ccol_d  = ccol_q;
        crow_d  = crow_q;
        frame_d = 1'b0;
        if (en) begin
            h_d = h_last ? '0 : h_q + 10'd1;
            if (h_last) begin
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end
        end
        // Entering vsync: VBL pulse, blink step and tear-free cursor latch
        if (en && h_last && (v_q == VS_PRE)) begin
            frame_d = 1'b1;
            cen_d   = cursor_en_i;
            ccol_d  = cursor_col_i;
            crow_d  = cursor_row_i;
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
        hsync_d  = !((h_d >= HS_START) && (h_d <= HS_END));
        vsync_d  = !((v_d >= VS_START) && (v_d <= VS_END));
        von_d    = (h_d < H_DISP) && (v_d < V_DISP);
        cursor_d = von_d && cen_d && blink_d
                   && (ccol_d == h_d[9:3]) && (crow_d == v_d[8:4])
                   && (v_d[3:0] >= CUR_TOP);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            bcnt_q   <= '0;
            blink_q  <= 1'b1;
            cen_q    <= 1'b0;
            ccol_q   <= '0;
            crow_q   <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            von_q    <= 1'b0;
            cursor_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            bcnt_q   <= bcnt_d;
            blink_q  <= blink_d;
            cen_q    <= cen_d;
            ccol_q   <= ccol_d;
            crow_q   <= crow_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            von_q    <= von_d;
            cursor_q <= cursor_d;
            frame_q  <= frame_d;
        end
    end

    assign en_o       = en;
    assign hsync_o    = hsync_q;
    assign vsync_o    = vsync_q;
    assign video_on_o = von_q;
    assign col_o      = h_q[9:3];
    assign row_o      = v_q[8:4];
    assign glyph_x_o  = h_q[2:0];
    assign glyph_y_o  = v_q[3:0];
    assign cursor_o   = cursor_q;
    assign frame_o    = frame_q;

endmodule

// File: tb/tb_vga_crtc.sv
// Bench for vga_crtc on a shrunken raster so several frames and blink phases fit.
// Reference model derives every output from the clock count since reset.
module tb_vga_crtc;

    localparam int DIV = 4;
    localparam int HD = 32, HF = 4, HS = 8, HB = 4;
    localparam int VD = 48, VF = 3, VS = 2, VB = 3;
    localparam int CT = 14;
    localparam int BF = 2;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;

    typedef struct packed {
        logic       en;
        logic       hs;
        logic       vs;
        logic       von;
        logic [6:0] col;
        logic [4:0] row;
        logic [2:0] gx;
        logic [3:0] gy;
        logic       cur;
        logic       frm;
    } out_t;

    localparam out_t RST_OUT = '{en: 1'b0, hs: 1'b1, vs: 1'b1, von: 1'b0,
                                 col: 7'd0, row: 5'd0, gx: 3'd0, gy: 4'd0,
                                 cur: 1'b0, frm: 1'b0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cursor_en = 1'b0;
    logic [6:0] cursor_col = '0;
    logic [4:0] cursor_row = '0;
    logic       en_o, hsync_o, vsync_o, video_on_o, cursor_o, frame_o;
    logic [6:0] col_o;
    logic [4:0] row_o;
    logic [2:0] glyph_x_o;
    logic [3:0] glyph_y_o;

    int   n_cmp = 0;
    int   n_bad = 0;
    out_t exp_q[$];

    int   e = 0, frames = 0;
    bit   l_en = 0;
    int   l_col = 0, l_row = 0;
    int   exp_cur_px = 0, dut_cur_px = 0;
    int   exp_frames = 0, dut_frames = 0;

    vga_crtc #(
        .CLK_DIV(DIV), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CURSOR_TOP(CT), .BLINK_FRAMES(BF)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cursor_en_i(cursor_en), .cursor_col_i(cursor_col),
        .cursor_row_i(cursor_row),
        .en_o(en_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .video_on_o(video_on_o), .col_o(col_o), .row_o(row_o),
        .glyph_x_o(glyph_x_o), .glyph_y_o(glyph_y_o),
        .cursor_o(cursor_o), .frame_o(frame_o)
    );

    always #5 clk = ~clk;

    function automatic out_t dut_out();
        out_t a;
        a = '{en: en_o, hs: hsync_o, vs: vsync_o, von: video_on_o,
              col: col_o, row: row_o, gx: glyph_x_o, gy: glyph_y_o,
              cur: cursor_o, frm: frame_o};
        return a;
    endfunction

    // Model: pixel n = e / DIV, raster position from plain division
    always @(posedge clk) begin
        out_t x;
        int n, h, v;
        bit fe, blink;
        x = RST_OUT;
        if (!rst_n) begin
            e = 0;
            frames = 0;
            l_en = 0;
            l_col = 0;
            l_row = 0;
        end else begin
            e++;
            n = e / DIV;
            h = n % HT;
            v = (n / HT) % VT;
            fe = (e % DIV == 0) && (h == 0) && (v == VD + VF);
            if (fe) begin
                frames++;
                l_en = cursor_en;
                l_col = int'(cursor_col);
                l_row = int'(cursor_row);
            end
            blink = ((frames / BF) % 2) == 0;
            x.en  = (e % DIV) == DIV - 1;
            x.hs  = !(h >= HD + HF && h < HD + HF + HS);
            x.vs  = !(v >= VD + VF && v < VD + VF + VS);
            x.von = (h < HD) && (v < VD);
            x.col = 7'(h / 8);
            x.row = 5'(v / 16);
            x.gx  = 3'(h % 8);
            x.gy  = 4'(v % 16);
            x.cur = x.von && l_en && blink && (h / 8 == l_col)
                    && (v / 16 == l_row) && (v % 16 >= CT);
            x.frm = fe;
        end
        exp_q.push_back(x);
    end

    always @(negedge clk) begin
        out_t x, a;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            a = dut_out();
            n_cmp++;
            exp_cur_px += int'(x.cur);
            dut_cur_px += int'(a.cur);
            exp_frames += int'(x.frm);
            dut_frames += int'(a.frm);
            if (a !== x) begin
                n_bad++;
                $display("FAIL outputs t=%0t got=%h want=%h", $time, a, x);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic new_cursor();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) begin
            cursor_en = 1'b1;
            cursor_col = 7'd2;
            cursor_row = 5'd1;
        end else if (r == 6) begin
            cursor_en = 1'($urandom_range(0, 1));
            cursor_col = 7'($urandom_range(0, 3));
            cursor_row = 5'($urandom_range(0, 2));
        end else if (r == 7) begin
            cursor_en = 1'b1;
            cursor_col = 7'd80;
            cursor_row = 5'd1;
        end else if (r == 8) begin
            cursor_en = 1'b1;
            cursor_col = 7'd2;
            cursor_row = 5'd30;
        end else begin
            cursor_en = 1'b0;
            cursor_col = 7'd2;
            cursor_row = 5'd1;
        end
    endtask

    initial begin
        step(3);
        cursor_en = 1'b1;
        cursor_col = 7'd2;
        cursor_row = 5'd1;
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step($urandom_range(1000, 3000));
            new_cursor();
        end
        step($urandom_range(100, 4000));
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_out() !== RST_OUT) begin
            n_bad++;
            $display("FAIL async_reset got=%h want=%h", dut_out(), RST_OUT);
        end
        step(3);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step($urandom_range(1500, 3000));
            new_cursor();
        end
        step(2);
        n_cmp++;
        if (dut_cur_px !== exp_cur_px || exp_cur_px == 0) begin
            n_bad++;
            $display("FAIL cursor_pixels got=%0d want=%0d (nonzero)",
                     dut_cur_px, exp_cur_px);
        end
        n_cmp++;
        if (dut_frames !== exp_frames || exp_frames < 3) begin
            n_bad++;
            $display("FAIL frame_pulses got=%0d want=%0d (at least 3)",
                     dut_frames, exp_frames);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
